mem_port_arbiter: RTL and testbench

- Shares the single-port 32x16 unified memory between two requesters of the multicycle processor: the instruction-fetch port (read-only) and the data port (read/write).
- Generates the memory's active-low write and read strobes and its address and data-in bus.
- Arbitrates round-robin, and blocks data-port writes into the boot-code region.
- Runs on the posedge of clk; the memory samples on the following negedge.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports, the memory-side bus and the status
// outputs of mem_port_arbiter. The arbiter binds the slave modport; a
// requester/memory model binds the master modport.
//
// Handshake: a requester raises req with its payload and keeps both stable
// until the matching ack pulses for one cycle; rdata (and d_err for data
// writes) are valid with that ack and hold afterwards. A req still high in
// the cycle after ack is treated as a fresh request.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  // memory bus (strobes active-low)
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_out;
  // status / debug
  logic              busy;
  logic [1:0]        dbg_state;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
    output if_ack, if_rdata, d_ack, d_rdata, d_err,
    output mem_address, mem_in, mem_write, mem_read, busy, dbg_state
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
    input  if_ack, if_rdata, d_ack, d_rdata, d_err,
    input  mem_address, mem_in, mem_write, mem_read, busy, dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port unified memory between the
// fetch port (read-only) and the data port (read/write). Every access takes
// IDLE -> ISSUE -> RESP; the memory acts on the negedge inside ISSUE and the
// owner's ack is high during RESP. Data writes below PROT_TOP are dropped
// (strobes stay high) but still acknowledged with d_err.
module mem_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int PROT_TOP = 5
) (
  input  logic                clk,
  input  logic                proc_rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam logic              PROT_EN  = (PROT_TOP > 0);
  localparam logic [ADDR_W:0]   PROT_LIM = (ADDR_W+1)'(PROT_TOP);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              blk_q, blk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic grant_data;
  logic addr_blocked;

  // Round-robin pick: on a tie the port that did not win last time goes.
  assign grant_data   = (bus.if_req && bus.d_req) ? (last_q == OWN_FETCH) : bus.d_req;
  assign addr_blocked = PROT_EN && ({1'b0, bus.d_addr} < PROT_LIM);

  // Next-state and output computation for the three-phase access sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    blk_d       = blk_q;
    addr_d      = addr_q;
    mem_in_d    = mem_in_q;
    mem_write_d = mem_write_q;
    mem_read_d  = mem_read_q;
    if_ack_d    = if_ack_q;
    d_ack_d     = d_ack_q;
    d_err_d     = d_err_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d = ST_ISSUE;
          owner_d = grant_data;
          last_d  = grant_data;
          if (grant_data == OWN_DATA) begin
            addr_d = bus.d_addr;
            we_d   = bus.d_we;
            blk_d  = bus.d_we && addr_blocked;
            if (!bus.d_we) begin
              mem_read_d = 1'b0;
            end else if (!addr_blocked) begin
              mem_write_d = 1'b0;
              mem_in_d    = bus.d_wdata;
            end
          end else begin
            addr_d     = bus.if_addr;
            we_d       = 1'b0;
            blk_d      = 1'b0;
            mem_read_d = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        // The memory has sampled on the negedge; close the access.
        state_d     = ST_RESP;
        mem_write_d = 1'b1;
        mem_read_d  = 1'b1;
        if (owner_q == OWN_FETCH) begin
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_out;
        end else begin
          d_ack_d = 1'b1;
          d_err_d = blk_q;
          if (!we_q) begin
            d_rdata_d = bus.mem_out;
          end
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
        d_err_d  = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_write_d = 1'b1;
        mem_read_d  = 1'b1;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_RESP);
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q     <= ST_IDLE;
      last_q      <= OWN_DATA;
      owner_q     <= OWN_FETCH;
      we_q        <= 1'b0;
      blk_q       <= 1'b0;
      addr_q      <= '0;
      mem_in_q    <= '0;
      mem_write_q <= 1'b1;
      mem_read_q  <= 1'b1;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      blk_q       <= blk_d;
      addr_q      <= addr_d;
      mem_in_q    <= mem_in_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_err       = d_err_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_in      = mem_in_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.busy        = busy_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 32x16 memory model on the negedge, a
// word-level reference memory plus round-robin bookkeeping, and one task
// per scenario.
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int PT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic proc_rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PROT_TOP(PT)) dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus)
  );

  // ---------------- physical memory (samples on negedge) ----------------
  logic [DW-1:0] mem [32];
  always @(negedge clk) begin
    if (!bus.mem_write) mem[bus.mem_address] = bus.mem_in;
    if (!bus.mem_read)  bus.mem_out = mem[bus.mem_address];
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] ref_mem [32];
  logic          m_last;        // 0 = fetch won last, 1 = data won last
  logic [DW-1:0] m_frd, m_drd;  // values the rdata outputs should hold
  logic [DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int wr_lows = 0;
  int rd_lows = 0;

  // Strobe sanity on every memory sampling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!bus.mem_read && !bus.mem_write) begin
        errors++;
        $display("FAIL strobe_excl: mem_read=%b mem_write=%b, not both 0 allowed", bus.mem_read, bus.mem_write);
      end
      checks++;
      if ((!bus.mem_read || !bus.mem_write) && !bus.busy) begin
        errors++;
        $display("FAIL strobe_idle: strobe low while busy=%b, required busy=1", bus.busy);
      end
      if (!bus.mem_write) wr_lows++;
      if (!bus.mem_read)  rd_lows++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    m_last = 1'b1;
    m_frd  = '0;
    m_drd  = '0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[1] = 16'h22E8; ref_mem[1] = 16'h22E8;
    mem[3] = 16'h22D1; ref_mem[3] = 16'h22D1;
  endtask

  // Issue one or both requests, wait (bounded) for their acks. A latency
  // of 0 means the ack never arrived.
  task automatic drive(input logic fe, input logic de, input logic [AW-1:0] fa,
                       input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       output int f_lat, output int d_lat,
                       output logic [DW-1:0] f_rd, output logic [DW-1:0] d_rd,
                       output logic d_er);
    f_lat = 0; d_lat = 0; f_rd = '0; d_rd = '0; d_er = 1'b0;
    for (int k = 0; k < 8 && bus.busy; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.if_req = fe; bus.if_addr = fa;
    bus.d_req = de; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (fe && f_lat == 0 && bus.if_ack) begin
        f_lat = i; f_rd = bus.if_rdata; bus.if_req = 1'b0;
      end
      if (de && d_lat == 0 && bus.d_ack) begin
        d_lat = i; d_rd = bus.d_rdata; d_er = bus.d_err; bus.d_req = 1'b0;
      end
      if ((!fe || f_lat != 0) && (!de || d_lat != 0)) break;
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    proc_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    mon_en = 1'b1;
    checks++;
    if ({bus.if_ack, bus.d_ack, bus.d_err, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: if_ack,d_ack,d_err,busy=%b required 0000", {bus.if_ack, bus.d_ack, bus.d_err, bus.busy});
    end
    checks++;
    if ({bus.mem_write, bus.mem_read} !== 2'b11) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 11", {bus.mem_write, bus.mem_read});
    end
    checks++;
    if (bus.if_rdata !== '0 || bus.d_rdata !== '0 || bus.mem_address !== '0 || bus.mem_in !== '0) begin
      errors++;
      $display("FAIL reset_buses: if_rdata=%h d_rdata=%h addr=%h mem_in=%h required all 0",
               bus.if_rdata, bus.d_rdata, bus.mem_address, bus.mem_in);
    end
    @(negedge clk);
    proc_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.if_ack, bus.d_ack, bus.mem_write, bus.mem_read} !== 5'b00011) begin
        errors++;
        $display("FAIL idle_quiet: busy,if_ack,d_ack,wr,rd=%b required 00011",
                 {bus.busy, bus.if_ack, bus.d_ack, bus.mem_write, bus.mem_read});
      end
    end
  endtask

  task automatic test_single_fetch();
    int fl, dl, rd0, wr0;
    logic [DW-1:0] fr, dr;
    logic de;
    rd0 = rd_lows; wr0 = wr_lows;
    drive(1'b1, 1'b0, 5'd1, 1'b0, 5'd0, 16'h0, fl, dl, fr, dr, de);
    m_last = 1'b0; m_frd = ref_mem[1];
    checks++;
    if (fl != 2) begin errors++; $display("FAIL fetch_latency: got %0d required 2", fl); end
    checks++;
    if (fr !== m_frd) begin errors++; $display("FAIL fetch_data: got %h required %h", fr, m_frd); end
    checks++;
    if (rd_lows - rd0 != 1 || wr_lows != wr0) begin
      errors++;
      $display("FAIL fetch_strobes: read lows %0d write lows %0d required 1 and 0", rd_lows - rd0, wr_lows - wr0);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.if_ack !== 1'b0 || bus.if_rdata !== m_frd) begin
      errors++;
      $display("FAIL fetch_pulse: if_ack=%b if_rdata=%h required 0 and %h", bus.if_ack, bus.if_rdata, m_frd);
    end
  endtask

  task automatic test_write_readback();
    int fl, dl, wr0;
    logic [DW-1:0] fr, dr;
    logic de;
    wr0 = wr_lows;
    drive(1'b0, 1'b1, 5'd0, 1'b1, 5'd20, 16'hBEEF, fl, dl, fr, dr, de);
    m_last = 1'b1; ref_mem[20] = 16'hBEEF;
    checks++;
    if (dl != 2 || de !== 1'b0) begin
      errors++; $display("FAIL write_ack: latency %0d d_err %b required 2 and 0", dl, de);
    end
    checks++;
    if (dr !== m_drd) begin errors++; $display("FAIL write_rdata_hold: got %h required %h", dr, m_drd); end
    checks++;
    if (wr_lows - wr0 != 1) begin errors++; $display("FAIL write_strobe: write lows %0d required 1", wr_lows - wr0); end
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd20, 16'h0, fl, dl, fr, dr, de);
    m_drd = ref_mem[20];
    checks++;
    if (dl != 2 || dr !== m_drd) begin
      errors++; $display("FAIL readback: latency %0d data %h required 2 and %h", dl, dr, m_drd);
    end
  endtask

  task automatic test_protected_write();
    int fl, dl, wr0;
    logic [DW-1:0] fr, dr;
    logic de;
    wr0 = wr_lows;
    drive(1'b0, 1'b1, 5'd0, 1'b1, 5'd3, 16'hFFFF, fl, dl, fr, dr, de);
    m_last = 1'b1;
    checks++;
    if (dl != 2 || de !== 1'b1) begin
      errors++; $display("FAIL prot_ack: latency %0d d_err %b required 2 and 1", dl, de);
    end
    checks++;
    if (wr_lows != wr0) begin errors++; $display("FAIL prot_strobe: write lows %0d required 0", wr_lows - wr0); end
    drive(1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 16'h0, fl, dl, fr, dr, de);
    m_last = 1'b0; m_frd = ref_mem[3];
    checks++;
    if (fl != 2 || fr !== m_frd) begin
      errors++; $display("FAIL prot_boot_word: latency %0d data %h required 2 and %h", fl, fr, m_frd);
    end
  endtask

  task automatic test_wrap();
    int fl, dl;
    logic [DW-1:0] fr, dr, v;
    logic de;
    v = DW'($urandom);
    drive(1'b0, 1'b1, 5'd0, 1'b1, 5'd31, v, fl, dl, fr, dr, de);
    ref_mem[31] = v; m_last = 1'b1;
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 16'h0, fl, dl, fr, dr, de);
    m_drd = ref_mem[0];
    checks++;
    if (dr !== m_drd) begin errors++; $display("FAIL wrap_addr0: got %h required %h", dr, m_drd); end
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd31, 16'h0, fl, dl, fr, dr, de);
    m_drd = ref_mem[31];
    checks++;
    if (dr !== m_drd) begin errors++; $display("FAIL wrap_addr31: got %h required %h", dr, m_drd); end
  endtask

  task automatic test_contention();
    int obs_port[$];
    int obs_cyc[$];
    logic [DW-1:0] obs_dat[$];
    logic p;
    @(negedge clk);
    proc_rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 5'd1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 5'd7; bus.d_wdata = '0;
    @(negedge clk); @(negedge clk);
    proc_rst = 1'b0;
    model_reset();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.if_ack) begin obs_port.push_back(0); obs_cyc.push_back(c); obs_dat.push_back(bus.if_rdata); end
      if (bus.d_ack)  begin obs_port.push_back(1); obs_cyc.push_back(c); obs_dat.push_back(bus.d_rdata); end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    checks++;
    if (obs_port.size() != 4) begin
      errors++; $display("FAIL contention_count: got %0d acks required 4", obs_port.size());
    end else begin
      p = ~m_last;
      for (int k = 0; k < 4; k++) begin
        logic [DW-1:0] ev;
        ev = p ? ref_mem[7] : ref_mem[1];
        checks++;
        if (obs_port[k] != int'(p) || obs_cyc[k] != 2 + 3*k || obs_dat[k] !== ev) begin
          errors++;
          $display("FAIL contention_ack%0d: port %0d cycle %0d data %h required port %0d cycle %0d data %h",
                   k, obs_port[k], obs_cyc[k], obs_dat[k], p, 2 + 3*k, ev);
        end
        m_last = p;
        p = ~p;
      end
    end
    m_last = 1'b1; m_frd = ref_mem[1]; m_drd = ref_mem[7];
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] v;
    int dl, fl;
    logic [DW-1:0] fr, dr;
    logic de;
    v = DW'($urandom);
    for (int k = 0; k < 8 && bus.busy; k++) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5'd20; bus.d_wdata = v;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL midop_issue: mem_write=%b required 0", bus.mem_write); end
    @(negedge clk);
    proc_rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.d_ack, bus.busy, bus.mem_write, bus.mem_read} !== 4'b0011) begin
      errors++;
      $display("FAIL midop_abort: d_ack,busy,wr,rd=%b required 0011", {bus.d_ack, bus.busy, bus.mem_write, bus.mem_read});
    end
    @(negedge clk);
    proc_rst = 1'b0;
    model_reset();
    dl = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.d_ack) begin dl = i; de = bus.d_err; break; end
    end
    bus.d_req = 1'b0;
    ref_mem[20] = v; m_last = 1'b1;
    checks++;
    if (dl != 2 || de !== 1'b0) begin
      errors++; $display("FAIL midop_retry: latency %0d d_err %b required 2 and 0", dl, de);
    end
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd20, 16'h0, fl, dl, fr, dr, de);
    m_drd = ref_mem[20];
    checks++;
    if (dr !== m_drd) begin errors++; $display("FAIL midop_readback: got %h required %h", dr, m_drd); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int mode, fl, dl;
      logic fe, de, dwe, first, exp_err, d_er;
      logic [AW-1:0] fa, da;
      logic [DW-1:0] dwd, fr, dr, ef, ed;
      mode = $urandom_range(0, 2);
      fe = (mode != 1); de = (mode != 0);
      fa = AW'($urandom_range(0, 31)); da = AW'($urandom_range(0, 31));
      dwe = 1'($urandom_range(0, 1)); dwd = DW'($urandom);
      first = (fe && de) ? ~m_last : de;
      exp_err = 1'b0;
      // Serve the ports in grant order against the reference memory.
      for (int s = 0; s < 2; s++) begin
        logic port;
        port = (s == 0) ? first : ~first;
        if (s == 1 && !(fe && de)) break;
        if (port == 1'b0) begin
          m_frd = ref_mem[fa];
          exp_q.push_back(m_frd);
        end else if (dwe) begin
          exp_err = (int'(da) < PT);
          if (!exp_err) ref_mem[da] = dwd;
          exp_q.push_back(m_drd);
        end else begin
          m_drd = ref_mem[da];
          exp_q.push_back(m_drd);
        end
        m_last = port;
      end
      drive(fe, de, fa, dwe, da, dwd, fl, dl, fr, dr, d_er);
      for (int s = 0; s < 2; s++) begin
        logic port;
        int lat;
        port = (s == 0) ? first : ~first;
        if (s == 1 && !(fe && de)) break;
        ef = exp_q.pop_front();
        lat = port ? dl : fl;
        checks++;
        if (lat != ((s == 0) ? 2 : 5)) begin
          errors++;
          $display("FAIL rand%0d_order: port %0d latency %0d required %0d", it, port, lat, (s == 0) ? 2 : 5);
        end
        checks++;
        if ((port ? dr : fr) !== ef) begin
          errors++;
          $display("FAIL rand%0d_data: port %0d got %h required %h", it, port, port ? dr : fr, ef);
        end
      end
      if (de) begin
        checks++;
        if (d_er !== exp_err) begin
          errors++; $display("FAIL rand%0d_err: d_err %b required %b", it, d_er, exp_err);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    proc_rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    init_mem();
    model_reset();
    test_reset();
    test_single_fetch();
    test_write_readback();
    test_protected_write();
    test_wrap();
    test_contention();
    test_reset_mid_op();
    test_random();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
